piezo_multi: RTL and testbench
==============================

PIEZO_MULTI -- requirements
Module: piezo_multi

Interface
REQ-001 Parameter NUM_CH, default 3: number of alert request channels (2..8).
REQ-002 Parameter NOTES, default 4: notes per channel sequence (1..8).
REQ-003 Parameter HALF_W, default 16: width of the note half-period count.
REQ-004 Parameter DUR_W, default 24: width of the note-duration and rest counts.
REQ-005 Parameter REST_CYC, default 2**22: silent cycles after each sequence.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 req  input  NUM_CH  level alert requests; bit 0 is steer-enable, bit 1 is over-speed, bit 2 is battery-low.
REQ-009 piezo  output  1  piezo drive, positive leg.
REQ-010 piezo_n  output  1  piezo drive, negative leg.
REQ-011 busy  output  1  high while in PLAY or REST.
REQ-012 active_ch  output  $clog2(NUM_CH)  currently granted channel.

Function
REQ-013 FSM states SHALL be IDLE, PLAY and REST.
REQ-014 IDLE->PLAY: on any req bit high, grant the first set bit searching round-robin from (last grant + 1) mod NUM_CH.
- Grant, active_ch, note index 0 and all counters SHALL be registered on the same edge.
REQ-015 Each note SHALL come from the package table: half_per (HALF_W bits) and dur (DUR_W bits), indexed by (active_ch, note index).
REQ-016 In PLAY, a half-period counter SHALL count 0..half_per-1; piezo SHALL toggle when it wraps. The first toggle occurs half_per cycles after PLAY entry.
REQ-017 In PLAY, a duration counter SHALL count 0..dur-1. On wrap:
- note index increments, and half-period counter and piezo clear;
- after note NOTES-1, the FSM goes to REST.
REQ-018 A note with half_per==0 SHALL be silent for its full duration.
REQ-019 REST SHALL last REST_CYC cycles with piezo silent, then return to IDLE.
REQ-020 Silent (IDLE, REST, half_per==0): piezo=0 and piezo_n=0. Sounding: piezo_n = ~piezo.
REQ-021 A sequence, once started, SHALL complete even if its req deasserts. Req changes during PLAY or REST SHALL have no effect until IDLE.
REQ-022 Simultaneous requests SHALL alternate sequences by round-robin, so over-speed and battery-low both sound.
REQ-023 With a single req held high, that channel SHALL repeat with period sum(dur)+REST_CYC+1 cycles.
REQ-024 Counters SHALL NOT wrap beyond their terminal values. dur==0 SHALL be treated as dur==1.

Reset
REQ-025 On rst_n low, asynchronously:
- state = IDLE;
- piezo = 0, piezo_n = 0, busy = 0, active_ch = 0;
- last grant = NUM_CH-1, so the first search starts at channel 0;
- all counters = 0.
REQ-026 Reset asserted mid-PLAY SHALL silence outputs immediately, with no completion of the sequence.

Configuration
REQ-027 Macro PIEZO_FAST_SIM_EN: when defined, the effective dur and REST_CYC SHALL each be right-shifted by 8, with a minimum of 1. half_per SHALL be unchanged.
REQ-028 Without PIEZO_FAST_SIM_EN, table and parameter values SHALL be used unscaled.

Structure
REQ-029 Package piezo_pkg SHALL hold:
- the note struct (half_per, dur);
- the per-channel note table constant;
- the state enum;
- the fast-sim shift constant.
REQ-030 One sub-module, piezo_tone_gen, SHALL hold the half-period counter and toggle flop. Its inputs SHALL be half_per and a clear/enable. Its output SHALL be the raw tone.

Verification
REQ-031 The bench SHALL cover the following scenarios.
- Reset, then req=000 for 1000 cycles -> piezo=0, piezo_n=0, busy=0 throughout.
- FAST_SIM, req=001 pulsed for 1 cycle -> ch0 plays all NOTES notes, then REST, then IDLE. Measured toggle spacing equals each table half_per. No repeat follows.
- req=110 held -> grants alternate ch1, ch2, ch1, ch2. active_ch matches each sequence.
- req=001 dropped mid-note 2 -> notes 2..NOTES-1 still play, then REST and IDLE.
- rst_n low during PLAY -> piezo and piezo_n are 0 in the same cycle. After release, IDLE re-grants from ch0.
- Table note with half_per=0 -> both legs low for exactly its dur cycles. Sounding notes always give piezo_n == ~piezo.

Source files
------------

// File: rtl/piezo_pkg.sv
// Shared types and the per-channel alert melody table for piezo_multi.
// Channel rows: 0 steer-enable, 1 over-speed, 2 battery-low; unused rows are silent.
package piezo_pkg;

  localparam int PKG_HALF_W = 16;
  localparam int PKG_DUR_W  = 24;
  localparam int TBL_CH     = 8;
  localparam int TBL_NOTES  = 8;
  localparam int FAST_SHIFT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_REST = 2'd2
  } state_e;

  typedef struct packed {
    logic [PKG_HALF_W-1:0] half_per;
    logic [PKG_DUR_W-1:0]  dur;
  } note_t;

  function automatic note_t mk_note(input int h, input int d);
    note_t n;
    n.half_per = PKG_HALF_W'(h);
    n.dur      = PKG_DUR_W'(d);
    return n;
  endfunction

  localparam note_t SILENT = '0;

  // half_per == 0 is a rest note; dur == 0 plays for one cycle.
  localparam note_t NOTE_TBL [TBL_CH][TBL_NOTES] = '{
    '{mk_note(5, 600), mk_note(7, 520), mk_note(0, 300), mk_note(4, 400),
      SILENT, SILENT, SILENT, SILENT},
    '{mk_note(3, 200), mk_note(6, 260), mk_note(9, 330), mk_note(2, 150),
      SILENT, SILENT, SILENT, SILENT},
    '{mk_note(8, 240), mk_note(4, 180), mk_note(10, 360), mk_note(5, 0),
      SILENT, SILENT, SILENT, SILENT},
    '{SILENT, SILENT, SILENT, SILENT, SILENT, SILENT, SILENT, SILENT},
    '{SILENT, SILENT, SILENT, SILENT, SILENT, SILENT, SILENT, SILENT},
    '{SILENT, SILENT, SILENT, SILENT, SILENT, SILENT, SILENT, SILENT},
    '{SILENT, SILENT, SILENT, SILENT, SILENT, SILENT, SILENT, SILENT},
    '{SILENT, SILENT, SILENT, SILENT, SILENT, SILENT, SILENT, SILENT}
  };

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator: toggles the tone every half_per enabled cycles.
// half_per == 0 holds the tone low; clear zeroes both counter and tone.
module piezo_tone_gen #(
  parameter int HALF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [HALF_W-1:0] half_per,
  output logic              tone
);

  logic [HALF_W-1:0] half_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      tone     <= 1'b0;
    end else if (clear) begin
      half_cnt <= '0;
      tone     <= 1'b0;
    end else if (enable && (half_per != '0)) begin
      if (half_cnt == half_per - HALF_W'(1)) begin
        half_cnt <= '0;
        tone     <= ~tone;
      end else begin
        half_cnt <= half_cnt + HALF_W'(1);
      end
    end
  end

endmodule

// File: rtl/piezo_multi.sv
// Multi-channel piezo alert sequencer with round-robin arbitration between requests.
// Define PIEZO_FAST_SIM_EN to shrink note durations and the rest period by 2**8 (minimum 1).
module piezo_multi
  import piezo_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int NOTES    = 4,
  parameter int HALF_W   = 16,
  parameter int DUR_W    = 24,
  parameter int REST_CYC = 2**22
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         req,
  output logic                      piezo,
  output logic                      piezo_n,
  output logic                      busy,
  output logic [$clog2(NUM_CH)-1:0] active_ch
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int NOTE_W = (NOTES > 1) ? $clog2(NOTES) : 1;

`ifdef PIEZO_FAST_SIM_EN
  localparam int REST_SCALED = REST_CYC >> FAST_SHIFT;
`else
  localparam int REST_SCALED = REST_CYC;
`endif
  localparam int REST_EFF = (REST_SCALED < 1) ? 1 : REST_SCALED;
  localparam logic [DUR_W-1:0] REST_LAST = DUR_W'(REST_EFF - 1);

  state_e              state;
  logic [CH_W-1:0]     last_grant;
  logic [CH_W-1:0]     grant;
  logic                found;
  logic [NOTE_W-1:0]   note_idx;
  logic [DUR_W-1:0]    dur_cnt;
  logic [DUR_W-1:0]    rest_cnt;
  note_t               cur_note;
  logic [PKG_DUR_W-1:0] dur_scaled;
  logic [DUR_W-1:0]    dur_eff;
  logic [DUR_W-1:0]    dur_last;
  logic [HALF_W-1:0]   half_per;
  logic                note_wrap;
  logic                last_note;
  logic                sounding;
  logic                tone;

  assign cur_note = NOTE_TBL[3'(active_ch)][3'(note_idx)];
  assign half_per = HALF_W'(cur_note.half_per);

  always_comb begin
`ifdef PIEZO_FAST_SIM_EN
    dur_scaled = cur_note.dur >> FAST_SHIFT;
`else
    dur_scaled = cur_note.dur;
`endif
    dur_eff = DUR_W'(dur_scaled);
    if (dur_eff == '0) dur_eff = DUR_W'(1);
    dur_last = dur_eff - DUR_W'(1);
  end

  // Round-robin: first pass above the last grant, second pass wraps to 0.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!found && req[c] && (c > int'(last_grant))) begin
        found = 1'b1;
        grant = CH_W'(c);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!found && req[c] && (c <= int'(last_grant))) begin
        found = 1'b1;
        grant = CH_W'(c);
      end
    end
  end

  assign note_wrap = (state == ST_PLAY) && (dur_cnt == dur_last);
  assign last_note = (note_idx == NOTE_W'(NOTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      active_ch  <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      note_idx   <= '0;
      dur_cnt    <= '0;
      rest_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state      <= ST_PLAY;
            active_ch  <= grant;
            last_grant <= grant;
            note_idx   <= '0;
            dur_cnt    <= '0;
            rest_cnt   <= '0;
          end
        end
        ST_PLAY: begin
          if (note_wrap) begin
            dur_cnt <= '0;
            if (last_note) begin
              state    <= ST_REST;
              note_idx <= '0;
              rest_cnt <= '0;
            end else begin
              note_idx <= note_idx + NOTE_W'(1);
            end
          end else begin
            dur_cnt <= dur_cnt + DUR_W'(1);
          end
        end
        ST_REST: begin
          if (rest_cnt == REST_LAST) begin
            state    <= ST_IDLE;
            rest_cnt <= '0;
          end else begin
            rest_cnt <= rest_cnt + DUR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Note boundaries restart the tone so every note begins low.
  piezo_tone_gen #(
    .HALF_W(HALF_W)
  ) u_tone (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   ((state != ST_PLAY) || note_wrap),
    .enable  (state == ST_PLAY),
    .half_per(half_per),
    .tone    (tone)
  );

  assign sounding = (state == ST_PLAY) && (half_per != '0);
  assign piezo    = sounding & tone;
  assign piezo_n  = sounding & ~tone;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_piezo_multi.sv
// Directed bench for piezo_multi: per-cycle tone model against a hand-entered note table.
// Works with or without PIEZO_FAST_SIM_EN defined.
module tb_piezo_multi;

  localparam int NUM_CH   = 3;
  localparam int NOTES    = 4;
  localparam int HALF_W   = 16;
  localparam int DUR_W    = 24;
  localparam int REST_CYC = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NUM_CH-1:0] req = '0;
  logic              piezo;
  logic              piezo_n;
  logic              busy;
  logic [1:0]        active_ch;

  int n_checks = 0;
  int n_fail   = 0;

  int tbl_h [3][4] = '{'{5, 7, 0, 4}, '{3, 6, 9, 2}, '{8, 4, 10, 5}};
  int tbl_d [3][4] = '{'{600, 520, 300, 400}, '{200, 260, 330, 150}, '{240, 180, 360, 0}};

  piezo_multi #(
    .NUM_CH  (NUM_CH),
    .NOTES   (NOTES),
    .HALF_W  (HALF_W),
    .DUR_W   (DUR_W),
    .REST_CYC(REST_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .piezo    (piezo),
    .piezo_n  (piezo_n),
    .busy     (busy),
    .active_ch(active_ch)
  );

  always #5 clk = ~clk;

  function automatic int eff_cyc(input int d);
    int r;
    r = d;
`ifdef PIEZO_FAST_SIM_EN
    r = r >> 8;
`endif
    if (r < 1) r = 1;
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at the sample point just after the granting edge; leaves at the IDLE sample.
  task automatic watch_seq(input int ch, input int drop_note, input int drop_cycle);
    int h, d, errs, exp_p, exp_n;
    for (int n = 0; n < NOTES; n++) begin
      h = tbl_h[ch][n];
      d = eff_cyc(tbl_d[ch][n]);
      errs = 0;
      for (int k = 0; k < d; k++) begin
        if (n == drop_note && k == drop_cycle) req = '0;
        exp_p = (h == 0) ? 0 : ((k / h) % 2);
        exp_n = (h == 0) ? 0 : 1 - exp_p;
        if (piezo !== exp_p[0] || piezo_n !== exp_n[0] || busy !== 1'b1 ||
            active_ch !== 2'(ch)) errs++;
        step();
      end
      check_eq($sformatf("ch%0d_note%0d_bad_cycles", ch, n), errs, 0);
    end
    errs = 0;
    for (int k = 0; k < eff_cyc(REST_CYC); k++) begin
      if (piezo !== 1'b0 || piezo_n !== 1'b0 || busy !== 1'b1) errs++;
      step();
    end
    check_eq($sformatf("ch%0d_rest_bad_cycles", ch), errs, 0);
    check_eq($sformatf("ch%0d_idle_busy", ch), busy, 0);
  endtask

  initial begin
    int errs, kk, exp_p;

    // Reset and quiet idle
    #2 rst_n = 1'b0;
    #21;
    check_eq("rst_piezo", piezo, 0);
    check_eq("rst_piezo_n", piezo_n, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_active_ch", active_ch, 0);
    step();
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      if (piezo !== 1'b0 || piezo_n !== 1'b0 || busy !== 1'b0) errs++;
      step();
    end
    check_eq("idle_quiet_cycles", errs, 0);

    // Single-cycle pulse on ch0: full sequence, no repeat
    req = 3'b001;
    step();
    watch_seq(0, 0, 0);
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy !== 1'b0) errs++;
      step();
    end
    check_eq("no_repeat_busy_cycles", errs, 0);

    // Two held requests alternate ch1, ch2, ch1, ch2
    req = 3'b110;
    step();
    watch_seq(1, -1, 0);
    step();
    watch_seq(2, -1, 0);
    step();
    watch_seq(1, -1, 0);
    step();
    watch_seq(2, 0, 0);
    step();
    check_eq("after_rr_busy", busy, 0);

    // ch0 dropped in the middle of its silent note 2
    req = 3'b001;
    step();
    watch_seq(0, 2, eff_cyc(300) / 2);

    // Reset during PLAY, then re-grant from ch0 with ch0 and ch1 requesting
    req = 3'b001;
    step();
    check_eq("pre_rst_active_ch", active_ch, 0);
    kk = eff_cyc(600) - 1;
    if (kk > 6) kk = 6;
    for (int i = 0; i < kk; i++) step();
    exp_p = (kk / 5) % 2;
    check_eq("pre_rst_piezo", piezo, exp_p);
    check_eq("pre_rst_piezo_n", piezo_n, 1 - exp_p);
    rst_n = 1'b0;
    #1;
    check_eq("midplay_rst_piezo", piezo, 0);
    check_eq("midplay_rst_piezo_n", piezo_n, 0);
    check_eq("midplay_rst_busy", busy, 0);
    check_eq("midplay_rst_active_ch", active_ch, 0);
    req = 3'b011;
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_rst_busy", busy, 1);
    check_eq("post_rst_grant", active_ch, 0);
    watch_seq(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
